// File: rtl/blk_mem_pkg.sv
// Shared types and width helpers for the dual-port block-read memory model.
package blk_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } port_state_t;

    function automatic int offset_w(input int block_words);
        return $clog2(block_words);
    endfunction

    function automatic int index_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int block_w(input int word_w, input int block_words);
        return word_w * block_words;
    endfunction

    function automatic int cnt_w(input int latency);
        return $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/blk_mem_dp_if.sv
// Request/response signal bundle for both ports of blk_mem_dp.
interface blk_mem_dp_if #(
    parameter int WORD_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int BLOCK_WORDS = 4
);
    logic                          req1_valid;
    logic                          req1_ready;
    logic [ADDR_W-1:0]             req1_addr;
    logic                          rsp1_valid;
    logic [WORD_W*BLOCK_WORDS-1:0] rsp1_data;

    logic                          req2_valid;
    logic                          req2_ready;
    logic                          req2_we;
    logic [ADDR_W-1:0]             req2_addr;
    logic [WORD_W-1:0]             req2_wdata;
    logic                          rsp2_valid;
    logic [WORD_W*BLOCK_WORDS-1:0] rsp2_data;

    modport master (
        output req1_valid, req1_addr,
        input  req1_ready, rsp1_valid, rsp1_data,
        output req2_valid, req2_we, req2_addr, req2_wdata,
        input  req2_ready, rsp2_valid, rsp2_data
    );

    modport slave (
        input  req1_valid, req1_addr,
        output req1_ready, rsp1_valid, rsp1_data,
        input  req2_valid, req2_we, req2_addr, req2_wdata,
        output req2_ready, rsp2_valid, rsp2_data
    );

endinterface

// File: rtl/blk_mem_port_fsm.sv
// Per-port handshake FSM: accepts a request, counts out the fixed latency and
// raises 'complete' during the cycle whose closing edge finishes the access.
module blk_mem_port_fsm
    import blk_mem_pkg::*;
#(
    parameter int WORD_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int LATENCY = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic              complete,
    output logic              lat_we,
    output logic [ADDR_W-1:0] lat_addr,
    output logic [WORD_W-1:0] lat_wdata
);
    localparam int              CNT_W    = cnt_w(LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    port_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             accept;

    assign req_ready = (state == IDLE) || (state == RESP);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == RESP);
    assign complete  = (state == BUSY) && (cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE, RESP: begin
                if (accept) begin
                    state_nxt = BUSY;
                    cnt_nxt   = CNT_LOAD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            BUSY: begin
                if (cnt == '0) state_nxt = RESP;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The write flag must not survive reset, or a dropped write could commit later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    lat_we <= 1'b0;
        else if (accept) lat_we <= req_we;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
        end
    end

endmodule

// File: rtl/blk_mem_dp.sv
// Dual-port fixed-latency block-read memory: port 1 reads blocks, port 2 reads
// blocks or writes words. Define PORT1_FWD_EN to forward same-edge port-2 writes into port-1 reads.
module blk_mem_dp
    import blk_mem_pkg::*;
#(
    parameter int WORD_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 256,
    parameter int BLOCK_WORDS = 4,
    parameter int LATENCY     = 5
) (
    input logic         clk,
    input logic         reset_n,
    blk_mem_dp_if.slave bus
);
    localparam int                 INDEX_W   = index_w(DEPTH);
    localparam int                 BLOCK_W   = block_w(WORD_W, BLOCK_WORDS);
    localparam logic [INDEX_W-1:0] BASE_MASK = ~INDEX_W'(BLOCK_WORDS - 1);

    logic [WORD_W-1:0] mem [DEPTH];

    logic               ready1, valid1, cmp1;
    logic               ready2, valid2, cmp2, we2;
    logic [ADDR_W-1:0]  lat_addr1, lat_addr2;
    logic [WORD_W-1:0]  wdata2;
    logic               unused_p1_we;
    logic [WORD_W-1:0]  unused_p1_wdata;
    logic               unused_addr_bits;
    logic [INDEX_W-1:0] idx1, idx2, base1, base2;
    logic [BLOCK_W-1:0] blk1, blk2, rsp1_data_q, rsp2_data_q;

    blk_mem_port_fsm #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .LATENCY(LATENCY)) u_port1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (bus.req1_valid),
        .req_we    (1'b0),
        .req_addr  (bus.req1_addr),
        .req_wdata ('0),
        .req_ready (ready1),
        .rsp_valid (valid1),
        .complete  (cmp1),
        .lat_we    (unused_p1_we),
        .lat_addr  (lat_addr1),
        .lat_wdata (unused_p1_wdata)
    );

    blk_mem_port_fsm #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .LATENCY(LATENCY)) u_port2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (bus.req2_valid),
        .req_we    (bus.req2_we),
        .req_addr  (bus.req2_addr),
        .req_wdata (bus.req2_wdata),
        .req_ready (ready2),
        .rsp_valid (valid2),
        .complete  (cmp2),
        .lat_we    (we2),
        .lat_addr  (lat_addr2),
        .lat_wdata (wdata2)
    );

    // Upper address bits are ignored so accesses wrap around the array.
    assign unused_addr_bits = ^{lat_addr1[ADDR_W-1:INDEX_W], lat_addr2[ADDR_W-1:INDEX_W]};
    assign idx1  = lat_addr1[INDEX_W-1:0];
    assign idx2  = lat_addr2[INDEX_W-1:0];
    assign base1 = idx1 & BASE_MASK;
    assign base2 = idx2 & BASE_MASK;

    always_comb begin
        blk1 = '0;
        blk2 = '0;
        for (int i = 0; i < BLOCK_WORDS; i++) begin
            blk1[i*WORD_W +: WORD_W] = mem[base1 | INDEX_W'(i)];
            blk2[i*WORD_W +: WORD_W] = mem[base2 | INDEX_W'(i)];
`ifdef PORT1_FWD_EN
            if (cmp2 && we2 && (idx2 == (base1 | INDEX_W'(i))))
                blk1[i*WORD_W +: WORD_W] = wdata2;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (cmp2 && we2) mem[idx2] <= wdata2;
    end

    // Read data persists until the next capture on that port; a write ack clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp1_data_q <= '0;
            rsp2_data_q <= '0;
        end else begin
            if (cmp1) rsp1_data_q <= blk1;
            if (cmp2) rsp2_data_q <= we2 ? '0 : blk2;
        end
    end

    assign bus.req1_ready = ready1;
    assign bus.rsp1_valid = valid1;
    assign bus.rsp1_data  = rsp1_data_q;
    assign bus.req2_ready = ready2;
    assign bus.rsp2_valid = valid2;
    assign bus.rsp2_data  = rsp2_data_q;

endmodule

// File: tb/tb_blk_mem_dp.sv
// Scoreboard bench for blk_mem_dp: array + pending-write reference model, randomized and directed traffic.
module tb_blk_mem_dp;
    localparam int WORD_W = 16;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 256;
    localparam int BW     = 4;
    localparam int LAT    = 5;
    localparam int BLK_W  = WORD_W * BW;
`ifdef PORT1_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef logic [BLK_W-1:0] blk_t;
    typedef struct { blk_t data; int due; } exp_t;
    typedef struct { bit we; logic [ADDR_W-1:0] addr; logic [WORD_W-1:0] wdata; } req_t;
    typedef struct { int idx; logic [WORD_W-1:0] data; int acc; } wr_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    blk_mem_dp_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .BLOCK_WORDS(BW)) bus ();

    blk_mem_dp #(
        .WORD_W(WORD_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BLOCK_WORDS(BW), .LATENCY(LAT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [WORD_W-1:0] model_mem [DEPTH];
    wr_t  pend_wr[$];
    exp_t exp1[$], exp2[$];
    req_t rq1[$], rq2[$];
    int   acc1_edges[$];
    int   errors = 0;
    int   checks = 0;
    blk_t last1, last2;

    function automatic void check(input string name, input blk_t act, input blk_t req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Reference: a read accepted at edge 'acc' sees every write accepted earlier,
    // and a write accepted on the same edge only when forwarding is allowed.
    function automatic blk_t model_block(input int idx, input int acc, input bit fwd_ok);
        blk_t b;
        int   base;
        base = idx & (DEPTH - 1) & ~(BW - 1);
        for (int w = 0; w < BW; w++) begin
            b[w*WORD_W +: WORD_W] = model_mem[base + w];
            foreach (pend_wr[j])
                if (pend_wr[j].idx == base + w &&
                    (pend_wr[j].acc < acc || (pend_wr[j].acc == acc && fwd_ok)))
                    b[w*WORD_W +: WORD_W] = pend_wr[j].data;
        end
        return b;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (bus.rsp1_valid) begin
                if (exp1.size() == 0) check("rsp1_spurious_valid", blk_t'(bus.rsp1_valid), '0);
                else begin
                    e = exp1.pop_front();
                    check("rsp1_data", bus.rsp1_data, e.data);
                    check("rsp1_cycle", blk_t'(cyc), blk_t'(e.due));
                    last1 = bus.rsp1_data;
                end
            end
            if (bus.rsp2_valid) begin
                if (exp2.size() == 0) check("rsp2_spurious_valid", blk_t'(bus.rsp2_valid), '0);
                else begin
                    e = exp2.pop_front();
                    check("rsp2_data", bus.rsp2_data, e.data);
                    check("rsp2_cycle", blk_t'(cyc), blk_t'(e.due));
                    last2 = bus.rsp2_data;
                end
            end
        end
    end

    task automatic tick();
        wr_t  w;
        req_t r;
        int   acc_e;
        int   idx;
        @(negedge clk);
        while (pend_wr.size() > 0 && pend_wr[0].acc + LAT <= cyc) begin
            w = pend_wr.pop_front();
            model_mem[w.idx] = w.data;
        end
        acc_e = cyc + 1;
        // Port 2 first so a same-edge write is already pending when port 1 is modelled.
        if (rq2.size() > 0) begin
            bus.req2_valid = 1'b1;
            bus.req2_we    = rq2[0].we;
            bus.req2_addr  = rq2[0].addr;
            bus.req2_wdata = rq2[0].wdata;
            if (bus.req2_ready) begin
                r   = rq2.pop_front();
                idx = int'(r.addr) & (DEPTH - 1);
                if (r.we) begin
                    pend_wr.push_back('{idx: idx, data: r.wdata, acc: acc_e});
                    exp2.push_back('{data: '0, due: acc_e + LAT});
                end else begin
                    exp2.push_back('{data: model_block(idx, acc_e, 1'b0), due: acc_e + LAT});
                end
            end
        end else begin
            bus.req2_valid = 1'b0;
            bus.req2_we    = 1'($urandom);
            bus.req2_addr  = ADDR_W'($urandom);
            bus.req2_wdata = WORD_W'($urandom);
        end
        if (rq1.size() > 0) begin
            bus.req1_valid = 1'b1;
            bus.req1_addr  = rq1[0].addr;
            if (bus.req1_ready) begin
                r   = rq1.pop_front();
                idx = int'(r.addr) & (DEPTH - 1);
                exp1.push_back('{data: model_block(idx, acc_e, FWD), due: acc_e + LAT});
                acc1_edges.push_back(acc_e);
            end
        end else begin
            bus.req1_valid = 1'b0;
            bus.req1_addr  = ADDR_W'($urandom);
        end
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((rq1.size() > 0 || rq2.size() > 0 || exp1.size() > 0 || exp2.size() > 0)
               && n < max_cyc) begin
            tick();
            n++;
        end
        tick();
        checks++;
        if (n >= max_cyc) begin
            errors++;
            $display("FAIL drain_timeout: still busy after %0d cycles, limit %0d", n, max_cyc);
        end
    endtask

    task automatic push_rd1(input logic [ADDR_W-1:0] a);
        rq1.push_back('{we: 1'b0, addr: a, wdata: '0});
    endtask

    task automatic push_req2(input bit we, input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d);
        rq2.push_back('{we: we, addr: a, wdata: d});
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req1_ready"}, blk_t'(bus.req1_ready), blk_t'(1));
        check({tag, "_req2_ready"}, blk_t'(bus.req2_ready), blk_t'(1));
        check({tag, "_rsp1_valid"}, blk_t'(bus.rsp1_valid), '0);
        check({tag, "_rsp2_valid"}, blk_t'(bus.rsp2_valid), '0);
        check({tag, "_rsp1_data"}, bus.rsp1_data, '0);
        check({tag, "_rsp2_data"}, bus.rsp2_data, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req1_valid = 1'b0;
        bus.req1_addr  = '0;
        bus.req2_valid = 1'b0;
        bus.req2_we    = 1'b0;
        bus.req2_addr  = '0;
        bus.req2_wdata = '0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        reset_n = 1'b1;

        // Fill the whole array so every later read has a known expectation.
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 'h21)      push_req2(1'b1, ADDR_W'(i), 16'h0000);
            else if (i == 'h30) push_req2(1'b1, ADDR_W'(i), 16'h5555);
            else                push_req2(1'b1, ADDR_W'(i), WORD_W'($urandom));
        end
        drain(2000);

        // Write then block read, including aligned and wrapped aliases.
        push_req2(1'b1, 16'h0012, 16'hBEEF);
        drain(50);
        check("write_ack_data", last2, '0);
        push_rd1(16'h0010);
        drain(50);
        check("read_0010_word2", blk_t'(last1[47:32]), blk_t'(16'hBEEF));
        push_rd1(16'h0013);
        drain(50);
        check("read_0013_word2", blk_t'(last1[47:32]), blk_t'(16'hBEEF));
        push_rd1(16'h0112);
        drain(50);
        check("read_0112_wrap_word2", blk_t'(last1[47:32]), blk_t'(16'hBEEF));

        // Same-edge port-1 read and port-2 write into that block.
        push_rd1(16'h0020);
        push_req2(1'b1, 16'h0021, 16'h1234);
        drain(50);
        check("same_edge_word1", blk_t'(last1[31:16]), FWD ? blk_t'(16'h1234) : blk_t'(16'h0000));
        push_rd1(16'h0020);
        drain(50);
        check("after_write_word1", blk_t'(last1[31:16]), blk_t'(16'h1234));

        // Back-to-back requests keep req1_valid high; accepts must be LAT+1 apart.
        acc1_edges.delete();
        for (int i = 0; i < 4; i++) push_rd1(ADDR_W'($urandom));
        drain(100);
        check("held_accept_count", blk_t'(acc1_edges.size()), blk_t'(4));
        for (int i = 1; i < acc1_edges.size(); i++)
            check("held_accept_spacing", blk_t'(acc1_edges[i] - acc1_edges[i-1]), blk_t'(LAT + 1));

        // Reset in the middle of a write drops it.
        push_req2(1'b1, 16'h0030, 16'hAAAA);
        begin
            int n;
            n = 0;
            while (rq2.size() > 0 && n < 20) begin tick(); n++; end
        end
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        check_reset_state("midreset");
        pend_wr.delete();
        exp1.delete();
        exp2.delete();
        rq1.delete();
        rq2.delete();
        bus.req1_valid = 1'b0;
        bus.req2_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        push_rd1(16'h0030);
        drain(50);
        check("dropped_write_word0", blk_t'(last1[15:0]), blk_t'(16'h5555));

        // Both ports reading concurrently, staggered by two cycles.
        push_rd1(16'h0040);
        tick();
        tick();
        push_req2(1'b0, 16'h0085, '0);
        drain(50);

        // Randomized mixed traffic on both ports.
        for (int i = 0; i < 400; i++) begin
            if (rq1.size() == 0 && $urandom_range(0, 1) == 1) push_rd1(ADDR_W'($urandom));
            if (rq2.size() == 0 && $urandom_range(0, 1) == 1)
                push_req2(1'($urandom), ADDR_W'($urandom), WORD_W'($urandom));
            tick();
        end
        drain(100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
